// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Data-memory request/acknowledge bus between the MEM stage
//            (master) and a variable-latency data memory (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_if #(
  parameter int DSIZE = 32
);
  logic             req;
  logic             we;
  logic [DSIZE-1:0] addr;
  logic [DSIZE-1:0] wdata;
  logic [DSIZE-1:0] rdata;
  logic             ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM pipeline stage. Issues loads/stores over a req/ack bus,
//            stalls upstream while the access is outstanding, emits bubbles
//            to MEM_WB meanwhile, and passes non-memory ops through
//            combinationally.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT = 15,
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int ISIZE   = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             valid_in,
  input  wire logic [DSIZE-1:0] alu_in,
  input  wire logic [DSIZE-1:0] st_data_in,
  input  wire logic             MemRead_in,
  input  wire logic             MemWrite_in,
  input  wire logic             wen_in,
  input  wire logic [ASIZE-1:0] w_addr_in,
  input  wire logic [ISIZE-1:0] PC_in,
  input  wire logic             jal_in,
  input  wire logic             MemtoReg_in,
  output logic                  stall_out,
  mem_access_if.master          dmem,
  output logic                  mem_err,
  output logic [ISIZE-1:0]      PC_out,
  output logic [DSIZE-1:0]      w_data_out,
  output logic [ASIZE-1:0]      w_addr_out,
  output logic                  wen_out,
  output logic                  jal_out,
  output logic                  MemtoReg_out,
  output logic [DSIZE-1:0]      readMem_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic             mem_op;
  logic [7:0]       cnt;

  // Registered bus drive, held stable for the whole WAIT phase
  logic             req_r;
  logic             we_r;
  logic [DSIZE-1:0] addr_r;
  logic [DSIZE-1:0] wdata_r;

  // Instruction bundle captured when the access is issued
  logic [ISIZE-1:0] lat_pc;
  logic [DSIZE-1:0] lat_wdata;
  logic [ASIZE-1:0] lat_waddr;
  logic             lat_wen;
  logic             lat_jal;
  logic             lat_m2r;
  logic             lat_load;
  logic [DSIZE-1:0] lat_rdata;

  assign mem_op     = valid_in & (MemRead_in | MemWrite_in);
  assign dmem.req   = req_r;
  assign dmem.we    = we_r;
  assign dmem.addr  = addr_r;
  assign dmem.wdata = wdata_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state and MEM_WB-facing outputs (bubble unless passing through or finishing)
  always_comb begin
    next_state   = state;
    stall_out    = 1'b0;
    PC_out       = '0;
    w_data_out   = '0;
    w_addr_out   = '0;
    wen_out      = 1'b0;
    jal_out      = 1'b0;
    MemtoReg_out = 1'b0;
    readMem_out  = '0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_out  = 1'b1;
          next_state = WAIT;
        end else begin
          PC_out       = PC_in;
          w_data_out   = alu_in;
          w_addr_out   = w_addr_in;
          wen_out      = wen_in & valid_in;
          jal_out      = jal_in;
          MemtoReg_out = MemtoReg_in;
        end
      end
      WAIT: begin
        stall_out = 1'b1;
        if (dmem.ack || (cnt == TO_LAST)) next_state = DONE;
      end
      DONE: begin
        PC_out       = lat_pc;
        w_data_out   = lat_wdata;
        w_addr_out   = lat_waddr;
        wen_out      = lat_wen;
        jal_out      = lat_jal;
        MemtoReg_out = lat_m2r;
        readMem_out  = lat_rdata;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus request, timeout counter, error flag and bundle capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      cnt       <= '0;
      mem_err   <= 1'b0;
      lat_pc    <= '0;
      lat_wdata <= '0;
      lat_waddr <= '0;
      lat_wen   <= 1'b0;
      lat_jal   <= 1'b0;
      lat_m2r   <= 1'b0;
      lat_load  <= 1'b0;
      lat_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            req_r     <= 1'b1;
            we_r      <= MemWrite_in;
            addr_r    <= alu_in;
            wdata_r   <= st_data_in;
            cnt       <= '0;
            lat_pc    <= PC_in;
            lat_wdata <= alu_in;
            lat_waddr <= w_addr_in;
            lat_wen   <= wen_in & valid_in;
            lat_jal   <= jal_in;
            lat_m2r   <= MemtoReg_in;
            // Store wins when both read and write are flagged
            lat_load  <= ~MemWrite_in;
            lat_rdata <= '0;
          end
        end
        WAIT: begin
          if (dmem.ack) begin
            req_r <= 1'b0;
            if (lat_load) lat_rdata <= dmem.rdata;
          end else if (cnt == TO_LAST) begin
            // Abort: a load that never returned must not write the register file
            req_r     <= 1'b0;
            mem_err   <= 1'b1;
            lat_rdata <= '0;
            if (lat_load) lat_wen <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage: passthrough vector
//            table plus directed load/store/timeout/reset/back-to-back runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_in;
  logic [31:0] st_data_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        wen_in;
  logic [4:0]  w_addr_in;
  logic [31:0] PC_in;
  logic        jal_in;
  logic        MemtoReg_in;
  logic        stall_out;
  logic        mem_err;
  logic [31:0] PC_out;
  logic [31:0] w_data_out;
  logic [4:0]  w_addr_out;
  logic        wen_out;
  logic        jal_out;
  logic        MemtoReg_out;
  logic [31:0] readMem_out;

  mem_access_if #(.DSIZE(32)) dmem_bus ();

  mem_access_stage #(.TIMEOUT(15), .DSIZE(32), .ASIZE(5), .ISIZE(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .alu_in       (alu_in),
    .st_data_in   (st_data_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .wen_in       (wen_in),
    .w_addr_in    (w_addr_in),
    .PC_in        (PC_in),
    .jal_in       (jal_in),
    .MemtoReg_in  (MemtoReg_in),
    .stall_out    (stall_out),
    .dmem         (dmem_bus.master),
    .mem_err      (mem_err),
    .PC_out       (PC_out),
    .w_data_out   (w_data_out),
    .w_addr_out   (w_addr_out),
    .wen_out      (wen_out),
    .jal_out      (jal_out),
    .MemtoReg_out (MemtoReg_out),
    .readMem_out  (readMem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        valid, rd, wr, wen, jal, m2r;
    logic [31:0] alu, pc;
    logic [4:0]  waddr;
    logic        exp_stall, exp_wen;
    logic [31:0] exp_wdata, exp_pc;
    logic [4:0]  exp_waddr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; alu_in = 0; st_data_in = 0; MemRead_in = 0; MemWrite_in = 0;
    wen_in = 0; w_addr_in = 0; PC_in = 0; jal_in = 0; MemtoReg_in = 0;
  endtask

  task automatic set_mem(input logic wr, input logic [31:0] addr, input logic [31:0] sd,
                         input logic wen, input logic [4:0] wa, input logic [31:0] pc);
    valid_in = 1; alu_in = addr; st_data_in = sd; MemRead_in = ~wr; MemWrite_in = wr;
    wen_in = wen; w_addr_in = wa; PC_in = pc; jal_in = 0; MemtoReg_in = ~wr;
  endtask

  // Called in the IDLE cycle with a mem op applied; returns at the negedge of DONE.
  // k = WAIT cycle carrying ack (0 = never).
  task automatic run_access(input int k, input logic [31:0] rd, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                            output int stalls);
    int cyc;
    stalls = 0;
    cyc = 0;
    @(negedge clk);
    check("idle_req_low", dmem_bus.req, 0);
    check("idle_bubble", {stall_out, wen_out, w_data_out}, {1'b1, 1'b0, 32'h0});
    if (stall_out) stalls++;
    next_cycle();
    while (cyc < 40) begin
      cyc++;
      if (cyc == k) begin dmem_bus.ack = 1; dmem_bus.rdata = rd; end
      else          begin dmem_bus.ack = 0; dmem_bus.rdata = 32'hBAD0_0000; end
      @(negedge clk);
      if (!stall_out) break;
      stalls++;
      check("wait_bus", {dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata},
            {1'b1, exp_we, exp_addr, exp_wd});
      check("wait_bubble", {wen_out, w_data_out, readMem_out}, 65'h0);
      next_cycle();
    end
    dmem_bus.ack = 0;
    if (cyc >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_budget: stall never released after %0d cycles", cyc);
    end
  endtask

  int s1, s2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                valid rd wr wen jal m2r alu           pc          waddr stall wen wdata         pc          waddr
    vecs[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_1234,32'h100,5'd5, 1'b0,1'b1,32'h0000_1234,32'h100,5'd5};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_CAFE,32'h104,5'd3, 1'b0,1'b0,32'h0000_CAFE,32'h104,5'd3};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'hFFFF_FFFF,32'h200,5'd31,1'b0,1'b0,32'hFFFF_FFFF,32'h200,5'd31};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h0000_0040,32'h208,5'd7, 1'b0,1'b0,32'h0000_0040,32'h208,5'd7};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,32'h20C,5'd0, 1'b0,1'b1,32'h0000_0000,32'h20C,5'd0};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0000_0080,32'h210,5'd9, 1'b0,1'b0,32'h0000_0080,32'h210,5'd9};

    rst = 0;
    idle_inputs();
    dmem_bus.ack = 0;
    dmem_bus.rdata = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_bus", {dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata}, 66'h0);
    check("rst_err_stall", {mem_err, stall_out}, 2'b00);
    check("rst_outs", {w_data_out, wen_out, readMem_out, PC_out}, 97'h0);
    rst = 1;
    next_cycle();

    // Passthrough table
    for (int i = 0; i < 6; i++) begin
      valid_in = vecs[i].valid; MemRead_in = vecs[i].rd; MemWrite_in = vecs[i].wr;
      wen_in = vecs[i].wen; jal_in = vecs[i].jal; MemtoReg_in = vecs[i].m2r;
      alu_in = vecs[i].alu; PC_in = vecs[i].pc; w_addr_in = vecs[i].waddr;
      st_data_in = 32'h5555_AAAA;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), stall_out, vecs[i].exp_stall);
      check($sformatf("vec%0d_wen", i), wen_out, vecs[i].exp_wen);
      check($sformatf("vec%0d_wdata", i), w_data_out, vecs[i].exp_wdata);
      check($sformatf("vec%0d_pc_waddr", i), {PC_out, w_addr_out}, {vecs[i].exp_pc, vecs[i].exp_waddr});
      check($sformatf("vec%0d_flags_rdm", i), {jal_out, MemtoReg_out, readMem_out},
            {vecs[i].jal, vecs[i].m2r, 32'h0});
      check($sformatf("vec%0d_req", i), dmem_bus.req, 0);
      next_cycle();
    end

    // Load, ack on 3rd WAIT cycle
    set_mem(0, 32'h40, 32'h0, 1, 5'd7, 32'h300);
    run_access(3, 32'hDEAD_BEEF, 0, 32'h40, 32'h0, s1);
    check("load_stalls", s1, 4);
    check("load_rdm", readMem_out, 32'hDEAD_BEEF);
    check("load_done_ctl", {MemtoReg_out, wen_out, w_addr_out, stall_out}, {1'b1, 1'b1, 5'd7, 1'b0});
    check("load_done_pc_wd", {PC_out, w_data_out}, {32'h300, 32'h40});
    check("load_done_req", dmem_bus.req, 0);
    next_cycle();

    // Store, ack on 2nd WAIT cycle, then a stray ack in IDLE
    set_mem(1, 32'h80, 32'hA5A5, 0, 5'd0, 32'h304);
    MemRead_in = 1;
    run_access(2, 32'h1111_2222, 1, 32'h80, 32'hA5A5, s1);
    check("store_stalls", s1, 3);
    check("store_done", {wen_out, readMem_out, MemtoReg_out}, 34'h0);
    next_cycle();
    idle_inputs();
    valid_in = 1; alu_in = 32'h77; wen_in = 1; w_addr_in = 5'd2;
    dmem_bus.ack = 1; dmem_bus.rdata = 32'h9999;
    @(negedge clk);
    check("stray_ack_pass", {stall_out, wen_out, w_data_out, readMem_out}, {1'b0, 1'b1, 32'h77, 32'h0});
    next_cycle();
    dmem_bus.ack = 0;
    @(negedge clk);
    check("stray_ack_req", {dmem_bus.req, stall_out}, 2'b00);
    next_cycle();

    // Load timeout
    check("err_before_to", mem_err, 0);
    set_mem(0, 32'h44, 32'h0, 1, 5'd9, 32'h308);
    run_access(0, 32'h0, 0, 32'h44, 32'h0, s1);
    check("to_stalls", s1, 16);
    check("to_done", {dmem_bus.req, mem_err, wen_out, readMem_out}, {1'b0, 1'b1, 1'b0, 32'h0});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("to_err_sticky", mem_err, 1);
    next_cycle();

    // Reset in the middle of WAIT
    set_mem(0, 32'h48, 32'h0, 1, 5'd4, 32'h30C);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("pre_rst_req", {dmem_bus.req, stall_out}, 2'b11);
    rst = 0;
    idle_inputs();
    next_cycle();
    rst = 1;
    valid_in = 1; alu_in = 32'h55; wen_in = 1; w_addr_in = 5'd6;
    @(negedge clk);
    check("midrst_state", {dmem_bus.req, stall_out, mem_err}, 3'b000);
    check("midrst_pass", {wen_out, w_data_out}, {1'b1, 32'h55});
    next_cycle();
    @(negedge clk);
    check("midrst_req_stays", dmem_bus.req, 0);
    next_cycle();

    // Back-to-back loads, ack k=1
    set_mem(0, 32'h10, 32'h0, 1, 5'd1, 32'h400);
    run_access(1, 32'h0000_0111, 0, 32'h10, 32'h0, s1);
    check("b2b_a_stalls", s1, 2);
    check("b2b_a_result", {readMem_out, w_addr_out}, {32'h111, 5'd1});
    next_cycle();
    set_mem(0, 32'h14, 32'h0, 1, 5'd2, 32'h404);
    run_access(1, 32'h0000_0222, 0, 32'h14, 32'h0, s2);
    check("b2b_b_stalls", s2, 2);
    check("b2b_b_result", {readMem_out, w_addr_out}, {32'h222, 5'd2});
    next_cycle();
    idle_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
